secded_block_codec: RTL and testbench

- Parametrised memory-walking Hamming SECDED engine; hardware successor to the software encode/decode programs.
- On START it reads COUNT words from data memory at SRC_BASE and encodes or decodes each one. Each result is written back at DST_BASE.
- It then raises DONE.
- Sits beside the datapath data memory and shares the byte-wide port through an external arbiter.

---
 rtl/secded_block_codec_if.sv | 14 +
 rtl/secded_block_codec.sv | 199 +++++++++++++++++++
 tb/tb_secded_block_codec.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/secded_block_codec_if.sv
// Byte-wide data-memory port shared with the datapath through an external arbiter.
// Read data returns the cycle after mem_rd_en.
interface secded_block_codec_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic              mem_wr_en;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport master (output mem_addr, mem_rd_en, mem_wr_en, mem_wdata, input mem_rdata);
   modport slave  (input mem_addr, mem_rd_en, mem_wr_en, mem_wdata, output mem_rdata);
endinterface

// File: rtl/secded_block_codec.sv
// Memory-walking Hamming SECDED engine: reads COUNT words at SRC_BASE, encodes or
// decodes each one, writes the results at DST_BASE, then raises DONE.
module secded_block_codec #(
   parameter int K      = 11,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              START,
   input  logic              MODE,
   input  logic [ADDR_W-1:0] SRC_BASE,
   input  logic [ADDR_W-1:0] DST_BASE,
   input  logic [CNT_W-1:0]  COUNT,
   output logic              DONE,
   output logic [CNT_W-1:0]  single_cnt,
   output logic [CNT_W-1:0]  double_cnt,
   secded_block_codec_if.master mem
);
   function automatic int calc_r(input int k);
      int r;
      r = 1;
      while ((1 << r) < k + r + 1) r = r + 1;
      return r;
   endfunction

   localparam int R   = calc_r(K);
   localparam int N   = K + R + 1;
   localparam int BD  = (K + 7) / 8;
   localparam int BC  = (N + 7) / 8;
   localparam int BO  = (K + 9) / 8;
   localparam int BW  = 8 * BC;
   localparam int OW  = 8 * BO;
   localparam int BIW = $clog2(BC + 1);

   typedef enum logic [2:0] {IDLE, RD, CAP, CALC, WR, NXT, FIN} state_t;

   state_t            state, state_nx;
   logic              mode_q;
   logic [ADDR_W-1:0] src_ptr, dst_ptr;
   logic [CNT_W-1:0]  remain;
   logic [BIW-1:0]    bidx, rd_idx, in_last, out_last;
   logic              rd_vld;
   logic [BW-1:0]     in_buf, out_buf, calc_word;
   logic [N-1:0]      cw;
   logic [R-1:0]      syn;
   logic              par;
   logic [1:0]        status;

   // Data bits sit at every non-power-of-two position from 3 upward.
   function automatic logic [K-1:0] extract(input logic [N-1:0] c);
      logic [K-1:0] d;
      int j;
      d = '0;
      j = 0;
      for (int p = 3; p < N; p++)
         if ((p & (p - 1)) != 0) begin
            d[j] = c[p];
            j++;
         end
      return d;
   endfunction

   function automatic logic [N-1:0] encode(input logic [K-1:0] d);
      logic [N-1:0] c;
      logic         pb;
      int           j;
      c = '0;
      j = 0;
      for (int p = 3; p < N; p++)
         if ((p & (p - 1)) != 0) begin
            c[p] = d[j];
            j++;
         end
      for (int b = 0; b < R; b++) begin
         pb = 1'b0;
         for (int p = 1; p < N; p++)
            if (((p >> b) & 1) != 0) pb = pb ^ c[p];
         c[1 << b] = pb;
      end
      c[0] = ^c;
      return c;
   endfunction

   assign in_last  = mode_q ? BIW'(BC - 1) : BIW'(BD - 1);
   assign out_last = mode_q ? BIW'(BO - 1) : BIW'(BC - 1);

   always_comb begin
      cw  = in_buf[N-1:0];
      par = ^cw;
      syn = '0;
      for (int p = 1; p < N; p++)
         if (cw[p]) syn = syn ^ R'(p);
      status = 2'b00;
      // A syndrome pointing past the codeword cannot be a single flip.
      if (par) begin
         if (int'(syn) < N) begin
            cw[syn] = ~cw[syn];
            status  = 2'b01;
         end else begin
            status = 2'b10;
         end
      end else if (syn != '0) begin
         status = 2'b10;
      end
      calc_word = '0;
      if (mode_q) begin
         calc_word[K-1:0]     = extract(cw);
         calc_word[OW-1 -: 2] = status;
      end else begin
         calc_word[N-1:0] = encode(in_buf[K-1:0]);
      end
   end

   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) state <= IDLE;
      else          state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (START) state_nx = (COUNT == '0) ? FIN : RD;
         RD:      if (bidx == in_last) state_nx = CAP;
         CAP:     state_nx = CALC;
         CALC:    state_nx = WR;
         WR:      if (bidx == out_last) state_nx = NXT;
         NXT:     state_nx = (remain == CNT_W'(1)) ? FIN : RD;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Strobes decode straight from state so reset drops them without waiting for a clock.
   always_comb begin
      mem.mem_rd_en = 1'b0;
      mem.mem_wr_en = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      if (state == RD) begin
         mem.mem_rd_en = 1'b1;
         mem.mem_addr  = src_ptr;
      end
      if (state == WR) begin
         mem.mem_wr_en = 1'b1;
         mem.mem_addr  = dst_ptr;
         mem.mem_wdata = out_buf[{bidx, 3'b000} +: 8];
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         mode_q     <= 1'b0;
         src_ptr    <= '0;
         dst_ptr    <= '0;
         remain     <= '0;
         bidx       <= '0;
         rd_idx     <= '0;
         rd_vld     <= 1'b0;
         in_buf     <= '0;
         out_buf    <= '0;
         DONE       <= 1'b0;
         single_cnt <= '0;
         double_cnt <= '0;
      end else begin
         rd_vld <= (state == RD);
         rd_idx <= bidx;
         if (rd_vld) in_buf[{rd_idx, 3'b000} +: 8] <= mem.mem_rdata;
         case (state)
            IDLE: if (START) begin
               mode_q     <= MODE;
               src_ptr    <= SRC_BASE;
               dst_ptr    <= DST_BASE;
               remain     <= COUNT;
               bidx       <= '0;
               DONE       <= 1'b0;
               single_cnt <= '0;
               double_cnt <= '0;
            end
            RD: begin
               src_ptr <= src_ptr + 1'b1;
               bidx    <= (bidx == in_last) ? '0 : bidx + 1'b1;
            end
            CALC: begin
               out_buf <= calc_word;
               bidx    <= '0;
               if (mode_q && status == 2'b01 && single_cnt != '1) single_cnt <= single_cnt + 1'b1;
               if (mode_q && status == 2'b10 && double_cnt != '1) double_cnt <= double_cnt + 1'b1;
            end
            WR: begin
               dst_ptr <= dst_ptr + 1'b1;
               bidx    <= (bidx == out_last) ? '0 : bidx + 1'b1;
            end
            NXT:     remain <= remain - 1'b1;
            FIN:     DONE   <= 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_secded_block_codec.sv
// Directed bench: a K=11 codec and a K=4 codec, each on its own byte memory model.
module tb_secded_block_codec;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       st11 = 1'b0, md11 = 1'b0;
   logic [7:0] src11 = '0, dst11 = '0, cnt11 = '0;
   logic       done11;
   logic [7:0] sc11, dc11;
   logic       st4 = 1'b0, md4 = 1'b0;
   logic [7:0] src4 = '0, dst4 = '0, cnt4 = '0;
   logic       done4;
   logic [7:0] sc4, dc4;

   secded_block_codec_if #(.ADDR_W(8)) if11 ();
   secded_block_codec_if #(.ADDR_W(8)) if4 ();

   secded_block_codec #(.K(11), .ADDR_W(8), .CNT_W(8)) u11 (
      .CLK(clk), .RESET_N(rst_n), .START(st11), .MODE(md11), .SRC_BASE(src11),
      .DST_BASE(dst11), .COUNT(cnt11), .DONE(done11), .single_cnt(sc11),
      .double_cnt(dc11), .mem(if11));

   secded_block_codec #(.K(4), .ADDR_W(8), .CNT_W(8)) u4 (
      .CLK(clk), .RESET_N(rst_n), .START(st4), .MODE(md4), .SRC_BASE(src4),
      .DST_BASE(dst4), .COUNT(cnt4), .DONE(done4), .single_cnt(sc4),
      .double_cnt(dc4), .mem(if4));

   logic [7:0] m11 [256];
   logic [7:0] m4  [256];
   int         wr11 = 0, strb11 = 0, overlap = 0;
   logic [7:0] rdlog4 [$];

   always @(posedge clk) begin
      if (if11.mem_rd_en) if11.mem_rdata <= m11[if11.mem_addr];
      if (if11.mem_wr_en) begin
         m11[if11.mem_addr] <= if11.mem_wdata;
         wr11++;
      end
      if (if11.mem_rd_en || if11.mem_wr_en) strb11++;
      if (if11.mem_rd_en && if11.mem_wr_en) overlap++;
      if (if4.mem_rd_en) begin
         if4.mem_rdata <= m4[if4.mem_addr];
         rdlog4.push_back(if4.mem_addr);
      end
      if (if4.mem_wr_en) m4[if4.mem_addr] <= if4.mem_wdata;
      if (if4.mem_rd_en && if4.mem_wr_en) overlap++;
   end

   // cyc = clock edges from the START-sampling edge until DONE is seen high.
   task automatic run11(input logic mode, input logic [7:0] src, dst, cnt,
                        input bit glitch, output int cyc);
      @(negedge clk);
      md11 = mode; src11 = src; dst11 = dst; cnt11 = cnt; st11 = 1'b1;
      @(negedge clk);
      st11 = 1'b0;
      checks++;
      if (done11 !== 1'b0) begin
         errors++;
         $display("FAIL done_clear11: got %b want 0", done11);
      end
      cyc = 0;
      if (glitch) begin
         md11 = ~mode; src11 = 8'h80; cnt11 = 8'd1; st11 = 1'b1;
         @(negedge clk);
         st11 = 1'b0; md11 = mode;
         cyc = 1;
      end
      while (done11 !== 1'b1 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (done11 !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout11: DONE=%b after %0d cycles, want 1", done11, cyc);
      end
   endtask

   task automatic run4(input logic mode, input logic [7:0] src, dst, cnt, output int cyc);
      @(negedge clk);
      md4 = mode; src4 = src; dst4 = dst; cnt4 = cnt; st4 = 1'b1;
      @(negedge clk);
      st4 = 1'b0;
      cyc = 0;
      while (done4 !== 1'b1 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (done4 !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout4: DONE=%b after %0d cycles, want 1", done4, cyc);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({done11, sc11, dc11, done4, sc4, dc4} !== '0) begin
         errors++;
         $display("FAIL reset_status: got %b/%h/%h %b/%h/%h want all 0", done11, sc11, dc11, done4, sc4, dc4);
      end
      checks++;
      if ({if11.mem_rd_en, if11.mem_wr_en, if11.mem_addr, if11.mem_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_bus: got rd=%b wr=%b addr=%h wdata=%h want all 0",
                  if11.mem_rd_en, if11.mem_wr_en, if11.mem_addr, if11.mem_wdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_encode;
      logic [7:0] exp_b [6];
      int cyc;
      exp_b = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h0F, 8'h00};
      m11[0] = 8'hFF; m11[1] = 8'h07; m11[2] = 8'h00; m11[3] = 8'h00; m11[4] = 8'h01; m11[5] = 8'h00;
      for (int i = 30; i < 36; i++) m11[i] = 8'hAA;
      run11(1'b0, 8'd0, 8'd30, 8'd3, 1'b0, cyc);
      checks++;
      if (cyc !== 22) begin
         errors++;
         $display("FAIL encode_latency: got %0d cycles want 22", cyc);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (m11[30+i] !== exp_b[i]) begin
            errors++;
            $display("FAIL encode_byte%0d: got %h want %h", i, m11[30+i], exp_b[i]);
         end
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({done11, sc11, dc11} !== {1'b1, 8'd0, 8'd0}) begin
         errors++;
         $display("FAIL encode_hold: got done=%b sc=%h dc=%h want 1/00/00", done11, sc11, dc11);
      end
   endtask

   task automatic test_decode_single;
      int cyc;
      m11[40] = 8'h2F; m11[41] = 8'h00; m11[42] = 8'h0E; m11[43] = 8'h00;
      run11(1'b1, 8'd40, 8'd50, 8'd2, 1'b0, cyc);
      checks++;
      if ({m11[51], m11[50], m11[53], m11[52]} !== 32'h4001_4001) begin
         errors++;
         $display("FAIL decode_single_data: got %h%h %h%h want 4001 4001", m11[51], m11[50], m11[53], m11[52]);
      end
      checks++;
      if ({sc11, dc11} !== {8'd2, 8'd0}) begin
         errors++;
         $display("FAIL decode_single_cnt: got sc=%0d dc=%0d want 2/0", sc11, dc11);
      end
   endtask

   task automatic test_decode_double;
      int cyc;
      m11[60] = 8'h2F; m11[61] = 8'h02; m11[62] = 8'hFF; m11[63] = 8'hFF;
      run11(1'b1, 8'd60, 8'd70, 8'd2, 1'b0, cyc);
      checks++;
      if ({m11[71], m11[70]} !== 16'h8013) begin
         errors++;
         $display("FAIL decode_double_data: got %h%h want 8013", m11[71], m11[70]);
      end
      checks++;
      if ({m11[73], m11[72]} !== 16'h07FF) begin
         errors++;
         $display("FAIL decode_allones_data: got %h%h want 07ff", m11[73], m11[72]);
      end
      checks++;
      if ({sc11, dc11} !== {8'd0, 8'd1}) begin
         errors++;
         $display("FAIL decode_double_cnt: got sc=%0d dc=%0d want 0/1", sc11, dc11);
      end
   endtask

   task automatic test_count_zero;
      int cyc, s0;
      s0 = strb11;
      run11(1'b0, 8'd0, 8'd90, 8'd0, 1'b0, cyc);
      checks++;
      if (cyc !== 1) begin
         errors++;
         $display("FAIL count0_latency: got %0d want 1", cyc);
      end
      checks++;
      if (strb11 - s0 !== 0) begin
         errors++;
         $display("FAIL count0_strobes: got %0d want 0", strb11 - s0);
      end
   endtask

   task automatic test_start_ignored;
      logic [7:0] exp_b [6];
      int cyc;
      exp_b = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h0F, 8'h00};
      run11(1'b0, 8'd0, 8'd100, 8'd3, 1'b1, cyc);
      checks++;
      if (cyc !== 22) begin
         errors++;
         $display("FAIL glitch_latency: got %0d want 22", cyc);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (m11[100+i] !== exp_b[i]) begin
            errors++;
            $display("FAIL glitch_byte%0d: got %h want %h", i, m11[100+i], exp_b[i]);
         end
      end
   endtask

   task automatic test_reset_mid_wr;
      logic [7:0] exp_b [6];
      int cyc, w0, n;
      exp_b = '{8'h01, 8'h40, 8'h01, 8'h00, 8'h13, 8'h80};
      m11[110] = 8'h2F; m11[111] = 8'h00; m11[112] = 8'h0F;
      m11[113] = 8'h00; m11[114] = 8'h2F; m11[115] = 8'h02;
      for (int i = 120; i < 126; i++) m11[i] = 8'hAA;
      @(negedge clk);
      md11 = 1'b1; src11 = 8'd110; dst11 = 8'd120; cnt11 = 8'd3; st11 = 1'b1;
      w0 = wr11;
      @(negedge clk);
      st11 = 1'b0;
      n = 0;
      while (!(if11.mem_wr_en === 1'b1 && wr11 - w0 == 2) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL midwr_reach: third write not seen within %0d cycles", n);
      end
      checks++;
      if (sc11 !== 8'd1) begin
         errors++;
         $display("FAIL midwr_pre_sc: got %0d want 1", sc11);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({if11.mem_wr_en, done11, sc11, dc11} !== '0) begin
         errors++;
         $display("FAIL midwr_async: got wr=%b done=%b sc=%0d dc=%0d want all 0",
                  if11.mem_wr_en, done11, sc11, dc11);
      end
      @(negedge clk);
      checks++;
      if ({m11[120], m11[121], m11[122]} !== 24'h0140AA) begin
         errors++;
         $display("FAIL midwr_partial: got %h %h %h want 01 40 aa", m11[120], m11[121], m11[122]);
      end
      rst_n = 1'b1;
      run11(1'b1, 8'd110, 8'd120, 8'd3, 1'b0, cyc);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (m11[120+i] !== exp_b[i]) begin
            errors++;
            $display("FAIL rerun_byte%0d: got %h want %h", i, m11[120+i], exp_b[i]);
         end
      end
      checks++;
      if ({sc11, dc11, cyc} !== {8'd1, 8'd1, 32'd22}) begin
         errors++;
         $display("FAIL rerun_cnt: got sc=%0d dc=%0d cyc=%0d want 1/1/22", sc11, dc11, cyc);
      end
   endtask

   task automatic test_k4_wrap;
      int cyc, n0;
      m4[254] = 8'h0F; m4[255] = 8'h05;
      n0 = rdlog4.size();
      run4(1'b0, 8'd254, 8'd10, 8'd2, cyc);
      checks++;
      if (rdlog4.size() - n0 !== 2 || rdlog4[n0] !== 8'd254 || rdlog4[n0+1] !== 8'd255) begin
         errors++;
         $display("FAIL k4_enc_reads: got %0d reads first=%0d want 2 reads 254,255", rdlog4.size() - n0, rdlog4[n0]);
      end
      checks++;
      if ({m4[10], m4[11], cyc} !== {8'hFF, 8'h5A, 32'd11}) begin
         errors++;
         $display("FAIL k4_enc_data: got %h %h cyc=%0d want ff 5a cyc=11", m4[10], m4[11], cyc);
      end
      m4[255] = 8'hFE; m4[0] = 8'h5A;
      n0 = rdlog4.size();
      run4(1'b1, 8'd255, 8'd20, 8'd2, cyc);
      checks++;
      if (rdlog4.size() - n0 !== 2 || rdlog4[n0] !== 8'd255 || rdlog4[n0+1] !== 8'd0) begin
         errors++;
         $display("FAIL k4_dec_reads: got %0d reads first=%0d want 2 reads 255,0", rdlog4.size() - n0, rdlog4[n0]);
      end
      checks++;
      if ({m4[20], m4[21], sc4, dc4} !== {8'h4F, 8'h05, 8'd1, 8'd0}) begin
         errors++;
         $display("FAIL k4_dec_data: got %h %h sc=%0d dc=%0d want 4f 05 1 0", m4[20], m4[21], sc4, dc4);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         m11[i] = 8'h00;
         m4[i]  = 8'h00;
      end
      test_reset;
      test_encode;
      test_decode_single;
      test_decode_double;
      test_count_zero;
      test_start_ignored;
      test_reset_mid_wr;
      test_k4_wrap;
      checks++;
      if (overlap !== 0) begin
         errors++;
         $display("FAIL rd_wr_overlap: got %0d cycles want 0", overlap);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
